// File: rtl/watch_pkg.sv
// watch_pkg: shared digit indices and 7-segment patterns for the watch display path
package watch_pkg;
  localparam int NUM_DIGITS = 6;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  localparam logic [2:0] IDX_S_UNI = 3'd0;
  localparam logic [2:0] IDX_S_DEZ = 3'd1;
  localparam logic [2:0] IDX_M_UNI = 3'd2;
  localparam logic [2:0] IDX_M_DEZ = 3'd3;
  localparam logic [2:0] IDX_H_UNI = 3'd4;
  localparam logic [2:0] IDX_H_DEZ = 3'd5;
  localparam logic [2:0] DP_IDX_MIN = 3'd2;
  localparam logic [2:0] DP_IDX_HOUR = 3'd4;
  // Patterns are {g,f,e,d,c,b,a}, active-low
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low 7-segment decoder, blank above 9
module bcd_to_7seg
  import watch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  // Map each BCD value to its pattern; non-decimal codes go dark
  always_comb begin
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: six-digit multiplexed 7-segment scanner with guard time, frame snapshot and config blink; LZ_BLANK_EN darkens a leading hour zero
module display_scan_ctrl
  import watch_pkg::*;
#(
  parameter int DIGIT_DIV = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s_unidade,
  input  logic [3:0] s_dezena,
  input  logic [3:0] m_unidade,
  input  logic [3:0] m_dezena,
  input  logic [3:0] h_unidade,
  input  logic [3:0] h_dezena,
  input  logic [2:0] config_digit,
  input  logic       is_config,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int SW = $clog2(DIGIT_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] r_slot;
  logic [2:0]    r_idx;
  logic [3:0]    r_snap [NUM_DIGITS];
  logic [BW-1:0] r_bcnt;
  logic          r_bon;
  logic          r_cfg_d;
  logic [2:0]    r_dig_d;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          w_slot_end, w_frame_end, w_bend, w_restart, w_on;
  logic          w_guard, w_blink, w_lz, w_dark, w_sep;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  assign w_slot_end  = r_slot == SW'(DIGIT_DIV - 1);
  assign w_frame_end = w_slot_end && r_idx == IDX_H_DEZ;
  assign w_bend      = r_bcnt == BW'(BLINK_DIV - 1);
  // A restart forces the phase on in the very cycle it is seen, so the new digit never flashes dark
  assign w_restart   = is_config && (!r_cfg_d || config_digit != r_dig_d);
  assign w_on        = r_bon || w_restart;
  assign w_guard     = r_slot < SW'(GUARD_CYCLES);
  assign w_blink     = is_config && !w_on && config_digit == r_idx;
`ifdef LZ_BLANK_EN
  assign w_lz        = !is_config && r_idx == IDX_H_DEZ && r_snap[IDX_H_DEZ] == 4'd0;
`else
  assign w_lz        = 1'b0;
`endif
  assign w_dark      = w_guard || w_blink || w_lz;
  assign w_sep       = r_idx == DP_IDX_MIN || r_idx == DP_IDX_HOUR;
  assign w_digit     = r_snap[r_idx];
  bcd_to_7seg u_dec (.i_bcd(w_digit), .o_seg(w_seg));
  // Slot timer, scan index and once-per-frame snapshot of the time digits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
      r_idx  <= '0;
      r_snap <= '{default: '0};
    end else begin
      r_slot <= w_slot_end ? '0 : r_slot + 1'b1;
      if (w_slot_end) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      if (w_frame_end) r_snap <= '{s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena};
    end
  end
  // Blink timer; held idle outside config mode and restarted on entry or digit change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcnt  <= '0;
      r_bon   <= 1'b1;
      r_cfg_d <= 1'b0;
      r_dig_d <= '0;
    end else begin
      r_cfg_d <= is_config;
      r_dig_d <= config_digit;
      r_bcnt  <= (!is_config || w_restart || w_bend) ? '0 : r_bcnt + 1'b1;
      r_bon   <= (!is_config || w_restart) ? 1'b1 : (w_bend ? !r_bon : r_bon);
    end
  end
  // Registered pin drivers: everything dark during guard, blink-off or leading-zero blanking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_dark ? 6'b111111 : ~(6'b000001 << r_idx);
      r_seg <= w_dark ? SEG_BLANK : w_seg;
      r_dp  <= w_dark || !w_sep;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes the watch's six BCD digits (HH:MM:SS from the mode FSM outputs) onto one shared 7-segment cathode bus with six common anodes.
- Sequences the display resource: digit scan order, anti-ghosting guard time, frame-coherent snapshot of the digits, and blinking of the digit selected in configuration mode.
- Sits between the mode FSM and the board pins; the only consumer of the FSM digit and config outputs.

Parameters:
- DIGIT_DIV, 50000, clk cycles per digit slot (≥2)
- GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off (< DIGIT_DIV)
- BLINK_DIV, 12500000, clk cycles per blink half-period

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_unidade  in  4  seconds units BCD (digit index 0)
- s_dezena  in  4  seconds tens BCD (index 1)
- m_unidade  in  4  minutes units BCD (index 2)
- m_dezena  in  4  minutes tens BCD (index 3)
- h_unidade  in  4  hours units BCD (index 4)
- h_dezena  in  4  hours tens BCD (index 5)
- config_digit  in  3  digit index under configuration, 0..5
- is_config  in  1  high while in configuration mode
- an  out  6  anode enables, active-low, bit i = digit index i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset, asynchronous: an=6'b111111, seg=7'b1111111, dp=1, scan index=0, slot counter=0, blink counter=0, blink phase=on, snapshot registers=0.
- Slot counter: counts 0..DIGIT_DIV-1.
  - At DIGIT_DIV-1 it wraps to 0 and the scan index advances 0→1→…→5→0.
- Snapshot: on the cycle the index wraps 5→0, all six inputs are latched into the snapshot. Display uses only the snapshot, so there is no tearing inside a frame. Input changes are visible from the next frame start; worst case is 6·DIGIT_DIV cycles.
- Guard: while slot counter < GUARD_CYCLES, an is all ones and seg is all ones.
- Active part of the slot: an drives a single zero at the current index; seg is the decode of snapshot[index].
- Decode: BCD 0..9 uses standard patterns. Values 10..15 produce all segments off.
- dp = 0 at indices 2 and 4 (HH.MM.SS separators), otherwise 1. dp is forced to 1 during guard and blanking.
- Blink, when is_config=1:
  - The blink counter counts 0..BLINK_DIV-1 and toggles the blink phase at wrap.
  - During the off phase, if index == config_digit, that anode stays high (digit dark).
  - config_digit > 5: no digit blinks.
- Blink restart: on an is_config rising edge or any change of config_digit, the counter is cleared and the phase is set to on in the same cycle. The newly selected digit is therefore immediately visible.
- is_config=0: blink counter held at 0, phase forced on.
- Output registering: an, seg and dp are registered, with 1 cycle latency from the internal index/counter state.
- Simultaneous events: slot wrap and blink toggle in the same cycle are independent. Blink restart has priority over blink toggle.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined: when is_config=0 and snapshot h_dezena==0, index 5 stays dark (anode high), so 09:05:00 shows as " 9.05.00". In configuration mode h_dezena is always shown.
- Undefined: leading zero is always displayed.

Decomposition:
- Package watch_pkg:
  - NUM_DIGITS=6
  - Digit index constants IDX_S_UNI..IDX_H_DEZ (0..5)
  - 7-bit segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - Separator dp index constants (2, 4)
- Sub-module bcd_to_7seg: combinational, 4-bit BCD in, 7-bit active-low segments out, blank for values >9. Instantiated once on the muxed snapshot digit.

Test Plan:
(Bench parameters: DIGIT_DIV=8, GUARD_CYCLES=2, BLINK_DIV=20.)
- Reset while running → an=111111, seg=1111111, dp=1 in the same cycle. After release, the first active anode is an=111110 at cycle 3 (2 guard cycles + 1 register latency).
- Inputs 12:34:56 held over two frames → second frame shows an/seg pairs in this order: idx0 '6', idx1 '5', idx2 '4' with dp=0, idx3 '3', idx4 '2' with dp=0, idx5 '1'. Guard gives an=111111 for 2 cycles per slot.
- Inputs change 12:34:56→12:34:57 mid-frame (during idx 3) → remainder of the frame still shows snapshot values; idx0 shows '7' only in the next frame.
- is_config=1, config_digit=2 → idx2 anode dark for 20 cycles and lit for 20 cycles, alternating; other digits unaffected. Changing config_digit to 3 during an off phase makes idx3 lit immediately, with the phase restarted.
- s_unidade=4'hB → idx0 active with seg=1111111 and dp=1.
- LZ_BLANK_EN defined, time 09:05:00, is_config=0 → idx5 anode stays high. With is_config=1, idx5 shows '0'.
